sd_read_arbiter: RTL

//  Shares one sd_controller between two block-read requesters (A = note-chart

---
 rtl/sd_read_arbiter_if.sv | 34 +++
 rtl/sd_read_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sd_read_arbiter_if.sv
// Signal bundle between the two block-read requesters, the arbiter and sd_controller.
interface sd_read_arbiter_if;
  logic        req_a;
  logic        req_b;
  logic [31:0] addr_a;
  logic [31:0] addr_b;
  logic        ack_a;
  logic        ack_b;
  logic [7:0]  rd_data;
  logic        valid_a;
  logic        valid_b;
  logic        done_a;
  logic        done_b;
  logic        err_a;
  logic        err_b;
  logic        busy;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_avail;
  logic        sd_ready;

  modport slave (
    input  req_a, req_b, addr_a, addr_b, sd_dout, sd_byte_avail, sd_ready,
    output ack_a, ack_b, rd_data, valid_a, valid_b, done_a, done_b,
           err_a, err_b, busy, sd_rd, sd_address
  );

  modport master (
    output req_a, req_b, addr_a, addr_b, sd_dout, sd_byte_avail, sd_ready,
    input  ack_a, ack_b, rd_data, valid_a, valid_b, done_a, done_b,
           err_a, err_b, busy, sd_rd, sd_address
  );
endinterface

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one sd_controller between two block-read requesters,
// with per-block byte counting, byte routing and a watchdog.
module sd_read_arbiter #(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT     = 1048576
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  sd_read_arbiter_if.slave  bus
);
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BLOCK_CNT = CW'(BLOCK_BYTES);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(TIMEOUT);
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef enum logic [2:0] {IDLE, ISSUE, XFER, DONE, FAIL} state_t;

  state_t        state, state_next;
  logic          owner, owner_next;
  logic          last_grant, last_grant_next;
  logic [CW-1:0] byte_cnt, byte_cnt_next;
  logic [WW-1:0] wdog, wdog_next, wdog_inc;
  logic          byte_prev;
  logic          byte_edge;
  logic          ack_a_next, ack_b_next;
  logic          valid_a_next, valid_b_next;
  logic          done_a_next, done_b_next;
  logic          err_a_next, err_b_next;
  logic          sd_rd_next;
  logic [31:0]   sd_address_next;
  logic [7:0]    rd_data_next;

  // sd_controller may hold byte_available for several cycles; only its rising edge is a byte
  assign byte_edge = bus.sd_byte_avail & ~byte_prev;
  assign wdog_inc  = (wdog == WDOG_MAX) ? wdog : wdog + 1'b1;
  assign bus.busy  = (state != IDLE);

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_grant_next = last_grant;
    byte_cnt_next   = byte_cnt;
    wdog_next       = wdog;
    sd_rd_next      = bus.sd_rd;
    sd_address_next = bus.sd_address;
    rd_data_next    = bus.rd_data;
    ack_a_next      = 1'b0;
    ack_b_next      = 1'b0;
    valid_a_next    = 1'b0;
    valid_b_next    = 1'b0;
    done_a_next     = 1'b0;
    done_b_next     = 1'b0;
    err_a_next      = 1'b0;
    err_b_next      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sd_ready && (bus.req_a || bus.req_b)) begin
          if (bus.req_a && bus.req_b) owner_next = ~last_grant;
          else                        owner_next = bus.req_b ? OWNER_B : OWNER_A;
          ack_a_next      = (owner_next == OWNER_A);
          ack_b_next      = (owner_next == OWNER_B);
          sd_address_next = (owner_next == OWNER_B) ? bus.addr_b : bus.addr_a;
          sd_rd_next      = 1'b1;
          byte_cnt_next   = '0;
          wdog_next       = '0;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        wdog_next = wdog_inc;
        if (!bus.sd_ready) begin
          sd_rd_next = 1'b0;
          wdog_next  = '0;
          state_next = XFER;
        end else if (wdog_inc == WDOG_MAX) begin
          sd_rd_next = 1'b0;
          state_next = FAIL;
        end
      end
      XFER: begin
        wdog_next = wdog_inc;
        if (byte_edge) begin
          wdog_next = '0;
          // bytes beyond a full block are swallowed so the requester never overruns
          if (byte_cnt < BLOCK_CNT) begin
            rd_data_next  = bus.sd_dout;
            valid_a_next  = (owner == OWNER_A);
            valid_b_next  = (owner == OWNER_B);
            byte_cnt_next = byte_cnt + 1'b1;
          end
        end
        if (bus.sd_ready)                            state_next = (byte_cnt == BLOCK_CNT) ? DONE : FAIL;
        else if (!byte_edge && wdog_inc == WDOG_MAX) state_next = FAIL;
      end
      DONE: begin
        done_a_next     = (owner == OWNER_A);
        done_b_next     = (owner == OWNER_B);
        last_grant_next = owner;
        state_next      = IDLE;
      end
      FAIL: begin
        done_a_next     = (owner == OWNER_A);
        done_b_next     = (owner == OWNER_B);
        err_a_next      = (owner == OWNER_A);
        err_b_next      = (owner == OWNER_B);
        last_grant_next = owner;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= OWNER_A;
      last_grant     <= OWNER_B;
      byte_cnt       <= '0;
      wdog           <= '0;
      byte_prev      <= 1'b0;
      bus.ack_a      <= 1'b0;
      bus.ack_b      <= 1'b0;
      bus.valid_a    <= 1'b0;
      bus.valid_b    <= 1'b0;
      bus.done_a     <= 1'b0;
      bus.done_b     <= 1'b0;
      bus.err_a      <= 1'b0;
      bus.err_b      <= 1'b0;
      bus.sd_rd      <= 1'b0;
      bus.sd_address <= '0;
      bus.rd_data    <= '0;
    end else begin
      state          <= state_next;
      owner          <= owner_next;
      last_grant     <= last_grant_next;
      byte_cnt       <= byte_cnt_next;
      wdog           <= wdog_next;
      byte_prev      <= bus.sd_byte_avail;
      bus.ack_a      <= ack_a_next;
      bus.ack_b      <= ack_b_next;
      bus.valid_a    <= valid_a_next;
      bus.valid_b    <= valid_b_next;
      bus.done_a     <= done_a_next;
      bus.done_b     <= done_b_next;
      bus.err_a      <= err_a_next;
      bus.err_b      <= err_b_next;
      bus.sd_rd      <= sd_rd_next;
      bus.sd_address <= sd_address_next;
      bus.rd_data    <= rd_data_next;
    end
  end
endmodule
